// File: rtl/slv_wresp_gen.sv
// Slave-side AXI write response generator: queues AW info, binds W beats to it in order,
// and issues one B per burst with DECERR/SLVERR/OKAY classification.
module slv_wresp_gen #(
   parameter int unsigned       TRANS_SLV_ID_W  = 7,
   parameter int unsigned       TRANS_WR_RESP_W = 2,
   parameter int unsigned       ADDR_W          = 32,
   parameter int unsigned       OUTSTANDING_AMT = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR       = 32'h0000_0000,
   parameter logic [ADDR_W-1:0] ADDR_SIZE       = 32'h0001_0000
) (
   input  logic                       ACLK_i,
   input  logic                       ARESET_i,
   input  logic [TRANS_SLV_ID_W-1:0]  s_AWID_i,
   input  logic [ADDR_W-1:0]          s_AWADDR_i,
   input  logic [7:0]                 s_AWLEN_i,
   input  logic                       s_AWVALID_i,
   output logic                       s_AWREADY_o,
   input  logic                       s_WLAST_i,
   input  logic                       s_WVALID_i,
   output logic                       s_WREADY_o,
   output logic [TRANS_SLV_ID_W-1:0]  s_BID_o,
   output logic [TRANS_WR_RESP_W-1:0] s_BRESP_o,
   output logic                       s_BVALID_o,
   input  logic                       s_BREADY_i,
   output logic                       wr_beat_o
);

   localparam int unsigned PtrW = (OUTSTANDING_AMT > 1) ? $clog2(OUTSTANDING_AMT) : 1;
   localparam logic [TRANS_WR_RESP_W-1:0] RespOkay   = TRANS_WR_RESP_W'(0);
   localparam logic [TRANS_WR_RESP_W-1:0] RespSlvErr = TRANS_WR_RESP_W'(2);
   localparam logic [TRANS_WR_RESP_W-1:0] RespDecErr = TRANS_WR_RESP_W'(3);

   logic [TRANS_SLV_ID_W-1:0] id_mem_q  [OUTSTANDING_AMT];
   logic [7:0]                len_mem_q [OUTSTANDING_AMT];
   logic                      dec_mem_q [OUTSTANDING_AMT];

   logic [PtrW:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [7:0]                  cnt_q, cnt_d;
   logic                        bvalid_q, bvalid_d;
   logic [TRANS_SLV_ID_W-1:0]   bid_q, bid_d;
   logic [TRANS_WR_RESP_W-1:0]  bresp_q, bresp_d;

   logic                        fifo_full, fifo_empty;
   logic                        aw_hs, w_hs, decerr, at_len, burst_end;
   logic [TRANS_SLV_ID_W-1:0]   head_id;
   logic [7:0]                  head_len;
   logic                        head_dec;
   logic [TRANS_WR_RESP_W-1:0]  resp;
   logic [ADDR_W:0]             addr_ext, base_ext, lim_ext;

   // Extra pointer bit distinguishes full from empty.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                       (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

   assign head_id  = id_mem_q[rd_ptr_q[PtrW-1:0]];
   assign head_len = len_mem_q[rd_ptr_q[PtrW-1:0]];
   assign head_dec = dec_mem_q[rd_ptr_q[PtrW-1:0]];

   assign addr_ext = {1'b0, s_AWADDR_i};
   assign base_ext = {1'b0, BASE_ADDR};
   assign lim_ext  = base_ext + {1'b0, ADDR_SIZE};
   assign decerr   = (addr_ext < base_ext) || (addr_ext >= lim_ext);

   assign s_AWREADY_o = ~fifo_full;
   assign s_WREADY_o  = ~fifo_empty & (~bvalid_q | s_BREADY_i);
   assign aw_hs       = s_AWVALID_i & s_AWREADY_o;
   assign w_hs        = s_WVALID_i & s_WREADY_o;
   assign wr_beat_o   = w_hs & ~head_dec;

   assign at_len    = (cnt_q == head_len);
   assign burst_end = s_WLAST_i | at_len;

   always_comb begin
      resp = RespOkay;
      if (head_dec) begin
         resp = RespDecErr;
      end else if (s_WLAST_i != at_len) begin
         resp = RespSlvErr;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{PtrW{1'b0}}, aw_hs};
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      bvalid_d = bvalid_q;
      bid_d    = bid_q;
      bresp_d  = bresp_q;
      if (bvalid_q && s_BREADY_i) begin
         bvalid_d = 1'b0;
      end
      if (w_hs) begin
         if (burst_end) begin
            rd_ptr_d = rd_ptr_q + {{PtrW{1'b0}}, 1'b1};
            cnt_d    = 8'd0;
            bvalid_d = 1'b1;
            bid_d    = head_id;
            bresp_d  = resp;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge ACLK_i) begin
      if (ARESET_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         bvalid_q <= 1'b0;
         bid_q    <= '0;
         bresp_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         bvalid_q <= bvalid_d;
         bid_q    <= bid_d;
         bresp_q  <= bresp_d;
      end
   end

   // Storage needs no reset; entries are only read while the pointers say they are valid.
   always_ff @(posedge ACLK_i) begin
      if (aw_hs) begin
         id_mem_q[wr_ptr_q[PtrW-1:0]]  <= s_AWID_i;
         len_mem_q[wr_ptr_q[PtrW-1:0]] <= s_AWLEN_i;
         dec_mem_q[wr_ptr_q[PtrW-1:0]] <= decerr;
      end
   end

   assign s_BVALID_o = bvalid_q;
   assign s_BID_o    = bid_q;
   assign s_BRESP_o  = bresp_q;

endmodule

// File: tb/tb_slv_wresp_gen.sv
// Bench for slv_wresp_gen: directed scenarios then random traffic, all checked every cycle
// against a queue-based model of the write-response rules.
module tb_slv_wresp_gen;

   localparam int    Depth = 8;
   localparam longint Base = 64'h0;
   localparam longint Size = 64'h1_0000;

   typedef struct {
      logic [6:0] id;
      int         len;
      bit         dec;
   } aw_t;

   logic        clk = 1'b0;
   logic        arst;
   logic [6:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic        awvalid, wlast, wvalid, bready;
   logic        awready, wready, bvalid, wr_beat;
   logic [6:0]  bid;
   logic [1:0]  bresp;

   int n_chk = 0;
   int n_pass = 0;
   int beat_cnt = 0;

   // Reference model state
   aw_t        q[$];
   int         beats;
   bit         m_bv;
   logic [6:0] m_bid;
   logic [1:0] m_bresp;

   always #5 clk = ~clk;

   slv_wresp_gen dut (
      .ACLK_i      (clk),
      .ARESET_i    (arst),
      .s_AWID_i    (awid),
      .s_AWADDR_i  (awaddr),
      .s_AWLEN_i   (awlen),
      .s_AWVALID_i (awvalid),
      .s_AWREADY_o (awready),
      .s_WLAST_i   (wlast),
      .s_WVALID_i  (wvalid),
      .s_WREADY_o  (wready),
      .s_BID_o     (bid),
      .s_BRESP_o   (bresp),
      .s_BVALID_o  (bvalid),
      .s_BREADY_i  (bready),
      .wr_beat_o   (wr_beat)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit in_window(input logic [31:0] a);
      longint la;
      la = longint'(a);
      return (la >= Base) && (la < Base + Size);
   endfunction

   task automatic model_clear();
      q.delete();
      beats   = 0;
      m_bv    = 1'b0;
      m_bid   = '0;
      m_bresp = '0;
   endtask

   // One clock: check outputs mid-cycle, then advance the model at the edge.
   task automatic cyc();
      bit  e_awr, e_wr, e_beat, on_len;
      aw_t e;
      @(negedge clk);
      e_awr  = q.size() < Depth;
      e_wr   = (q.size() != 0) && (!m_bv || bready);
      e_beat = wvalid && e_wr && !q[0].dec;
      chk("awready", 32'(awready), 32'(e_awr));
      chk("wready", 32'(wready), 32'(e_wr));
      chk("wr_beat", 32'(wr_beat), 32'(e_beat));
      chk("bvalid", 32'(bvalid), 32'(m_bv));
      if (m_bv) begin
         chk("bid", 32'(bid), 32'(m_bid));
         chk("bresp", 32'(bresp), 32'(m_bresp));
      end
      if (wr_beat) beat_cnt++;
      @(posedge clk);
      if (arst) begin
         model_clear();
      end else begin
         if (m_bv && bready) m_bv = 1'b0;
         if (wvalid && e_wr) begin
            on_len = (beats == q[0].len);
            if (wlast || on_len) begin
               m_bv    = 1'b1;
               m_bid   = q[0].id;
               m_bresp = q[0].dec ? 2'b11 : ((wlast != on_len) ? 2'b10 : 2'b00);
               void'(q.pop_front());
               beats = 0;
            end else begin
               beats++;
            end
         end
         if (awvalid && e_awr) begin
            e.id  = awid;
            e.len = int'(awlen);
            e.dec = !in_window(awaddr);
            q.push_back(e);
         end
      end
      #1;
   endtask

   task automatic aw(input logic [6:0] id, input logic [31:0] addr, input logic [7:0] len);
      awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
      cyc();
      awvalid = 1'b0;
   endtask

   task automatic wbeat(input logic last);
      wvalid = 1'b1; wlast = last;
      cyc();
      wvalid = 1'b0; wlast = 1'b0;
   endtask

   initial begin
      arst = 1'b1; awid = '0; awaddr = '0; awlen = '0;
      awvalid = 1'b0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_clear();
      arst = 1'b0;
      chk("rst_awready", 32'(awready), 32'd1);
      chk("rst_wready", 32'(wready), 32'd0);
      chk("rst_bvalid", 32'(bvalid), 32'd0);
      chk("rst_bid", 32'(bid), 32'd0);
      chk("rst_bresp", 32'(bresp), 32'd0);
      chk("rst_wr_beat", 32'(wr_beat), 32'd0);

      // Basic OKAY burst of four beats
      aw(7'd5, 32'h100, 8'd3);
      beat_cnt = 0;
      wbeat(1'b0); wbeat(1'b0); wbeat(1'b0); wbeat(1'b1);
      chk("ok_beats", 32'(beat_cnt), 32'd4);
      chk("ok_bvalid", 32'(bvalid), 32'd1);
      chk("ok_bid", 32'(bid), 32'd5);
      chk("ok_bresp", 32'(bresp), 32'd0);
      cyc();

      // Out-of-window address
      beat_cnt = 0;
      aw(7'd1, 32'h0001_0000, 8'd0);
      wbeat(1'b1);
      chk("dec_beats", 32'(beat_cnt), 32'd0);
      chk("dec_bresp", 32'(bresp), 32'd3);
      cyc();

      // Early WLAST then a normal single-beat burst
      aw(7'd2, 32'h200, 8'd3);
      wbeat(1'b0); wbeat(1'b1);
      chk("early_bresp", 32'(bresp), 32'd2);
      chk("early_bid", 32'(bid), 32'd2);
      aw(7'd3, 32'h10, 8'd0);
      wbeat(1'b1);
      chk("after_bresp", 32'(bresp), 32'd0);
      chk("after_bid", 32'(bid), 32'd3);
      cyc();

      // Fill the FIFO; a push must not sneak in alongside a pop while full
      for (int i = 0; i < 8; i++) aw(7'(i + 16), 32'(i * 16), 8'd0);
      chk("full_awready", 32'(awready), 32'd0);
      awvalid = 1'b1; awid = 7'd99; wvalid = 1'b1; wlast = 1'b1;
      cyc();
      awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
      chk("pop_awready", 32'(awready), 32'd1);
      for (int i = 0; i < 7; i++) wbeat(1'b1);
      chk("drain_bid", 32'(bid), 32'd23);
      cyc();

      // Backpressured B, then handshake and reload in the same cycle
      bready = 1'b0;
      aw(7'd7, 32'h40, 8'd0);
      aw(7'd8, 32'h80, 8'd0);
      wbeat(1'b1);
      wvalid = 1'b1; wlast = 1'b1;
      repeat (3) cyc();
      chk("bp_wready", 32'(wready), 32'd0);
      chk("bp_bid", 32'(bid), 32'd7);
      bready = 1'b1;
      cyc();
      wvalid = 1'b0; wlast = 1'b0;
      chk("b2b_bvalid", 32'(bvalid), 32'd1);
      chk("b2b_bid", 32'(bid), 32'd8);
      cyc();

      // Reset mid-burst with two AWs queued
      aw(7'd9, 32'h300, 8'd3);
      aw(7'd10, 32'h400, 8'd0);
      wbeat(1'b0);
      arst = 1'b1;
      cyc();
      arst = 1'b0;
      chk("mrst_bvalid", 32'(bvalid), 32'd0);
      chk("mrst_awready", 32'(awready), 32'd1);
      chk("mrst_wready", 32'(wready), 32'd0);
      wvalid = 1'b1; wlast = 1'b1;
      repeat (3) cyc();
      wvalid = 1'b0; wlast = 1'b0;
      chk("mrst_no_b", 32'(bvalid), 32'd0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         awvalid = ($urandom_range(0, 2) == 0);
         awid    = 7'($urandom_range(0, 127));
         awaddr  = ($urandom_range(0, 4) == 0) ? 32'h0001_0000 + 32'($urandom_range(0, 255))
                                               : 32'($urandom_range(0, 16'hFFFF));
         awlen   = 8'($urandom_range(0, 3));
         wvalid  = ($urandom_range(0, 1) == 1);
         if (q.size() != 0 && $urandom_range(0, 4) != 0) wlast = (beats == q[0].len);
         else wlast = ($urandom_range(0, 1) == 1);
         bready  = ($urandom_range(0, 3) != 0);
         arst    = ($urandom_range(0, 499) == 0);
         cyc();
      end
      arst = 1'b0; awvalid = 1'b0; wvalid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/slv_wresp_gen.md
SLV_WRESP_GEN -- requirements
Module: slv_wresp_gen

Interface
REQ-001 Parameters (name, default, meaning):
- TRANS_SLV_ID_W, 7: slave-side transaction ID width.
- TRANS_WR_RESP_W, 2: BRESP width.
- ADDR_W, 32: AWADDR width.
- OUTSTANDING_AMT, 8: AW info FIFO depth (power of 2).
- BASE_ADDR, 32'h0000_0000: first decoded byte address.
- ADDR_SIZE, 32'h0001_0000: decoded window size in bytes.
REQ-002 Ports (name, direction, width, meaning):
- ACLK_i, in, 1: clock; all logic rising-edge.
- ARESET_i, in, 1: reset, synchronous, active-high.
- s_AWID_i, in, TRANS_SLV_ID_W: write address ID.
- s_AWADDR_i, in, ADDR_W: burst start address.
- s_AWLEN_i, in, 8: beats minus one.
- s_AWVALID_i, in, 1: AW valid.
- s_AWREADY_o, out, 1: AW ready.
- s_WLAST_i, in, 1: last-beat marker from master.
- s_WVALID_i, in, 1: W valid.
- s_WREADY_o, out, 1: W ready.
- s_BID_o, out, TRANS_SLV_ID_W: response ID.
- s_BRESP_o, out, TRANS_WR_RESP_W: response code.
- s_BVALID_o, out, 1: response valid.
- s_BREADY_i, in, 1: response ready.
- wr_beat_o, out, 1: one-cycle strobe per accepted W beat of a decoded (non-DECERR) burst.

Function
REQ-003 AW handshake = s_AWVALID_i & s_AWREADY_o; pushes {AWID, AWLEN, decerr} into the AW info FIFO.
REQ-004 decerr = 1 when s_AWADDR_i < BASE_ADDR or s_AWADDR_i >= BASE_ADDR+ADDR_SIZE (compare at ADDR_W+1 bits, no wrap).
REQ-005 s_AWREADY_o = ~fifo_full, from registered state only; no push when full, even if a pop occurs in the same cycle.
REQ-006 s_WREADY_o = ~fifo_empty & (~s_BVALID_o | s_BREADY_i); an AW pushed into an empty FIFO serves W no earlier than the next cycle.
REQ-007 W beats bind to FIFO head entries in AW order (no WID).
REQ-008 Beat counter cnt, 8 bits, counts accepted beats of the head burst.
REQ-009 Burst end on W handshake when s_WLAST_i | (cnt == head AWLEN); on end: pop FIFO, cnt <= 0, load B register; otherwise cnt <= cnt+1.
REQ-010 Response code priority:
- DECERR (2'b11) if head decerr;
- else SLVERR (2'b10) if s_WLAST_i != (cnt == head AWLEN) (early WLAST, or missing WLAST at beat AWLEN+1);
- else OKAY (2'b00).
REQ-011 Missing WLAST terminates the burst at beat AWLEN+1; following beats bind to the next AW.
REQ-012 B register: s_BVALID_o set on load. It clears on B handshake when no load occurs in the same cycle. A simultaneous handshake and load replaces the contents and BVALID stays 1.
REQ-013 s_BID_o and s_BRESP_o are stable while s_BVALID_o & ~s_BREADY_i.
REQ-014 wr_beat_o = W handshake & ~head decerr, combinational, same cycle.
REQ-015 Latency: a final W beat accepted in cycle N gives s_BVALID_o = 1 in cycle N+1.
REQ-016 Responses issue in AW order; at most one B is pending.
REQ-017 Simultaneous FIFO push and pop when neither full nor empty: occupancy unchanged. Pointers wrap modulo OUTSTANDING_AMT.

Reset
REQ-018 While ARESET_i = 1 at a clock edge, the block resets:
- FIFO empty, pointers 0, cnt 0;
- s_BVALID_o = 0, s_BID_o = 0, s_BRESP_o = 0;
- s_AWREADY_o = 1, s_WREADY_o = 0, wr_beat_o = 0.
REQ-019 Reset mid-burst discards all pending AW info and any unaccepted B; no response is issued for them afterwards.

Verification
REQ-020 AWID=5, AWADDR=0x100, AWLEN=3, four W beats with WLAST on beat 4, BREADY=1 -> wr_beat_o pulses 4 times; one B with BID=5, BRESP=OKAY, one cycle after the last beat.
REQ-021 AWADDR=0x0001_0000 (outside the window), AWLEN=0 -> wr_beat_o stays 0; BRESP=DECERR.
REQ-022 AWLEN=3 with WLAST on beat 2 -> B with SLVERR after beat 2. Next AW (AWLEN=0, OKAY) completes normally.
REQ-023 Eight AWs issued before any W -> s_AWREADY_o = 0 on the ninth. After the first burst completes, a pop occurs and s_AWREADY_o returns to 1.
REQ-024 BREADY held 0 with B pending -> s_WREADY_o = 0 and BID/BRESP stable. BREADY=1 together with a final beat -> back-to-back B, BVALID held at 1.
REQ-025 ARESET_i asserted mid-burst with two AWs queued -> next cycle BVALID=0, AWREADY=1, WREADY=0. No B is issued for the flushed bursts.
